// File: rtl/ram2_ctrl.sv
// -----------------------------------------------------------------------------
// ram2_ctrl
//   Synchronous initiator for the single-port ram2 RAM and its bidirectional
//   data bus. Accepts read/write commands on a valid/ready handshake, drives
//   the RAM control pins from registers, owns the tri-state side of the data
//   bus and returns read data with a one-cycle response strobe.
//
// Optional feature (compile-time macro): RAM2_CTRL_INIT_EN
//   When defined, an INIT state follows reset and clears every RAM word to 0
//   before the first command is accepted. When undefined there is no INIT
//   state and init_done is tied high.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   cmd_valid  in   command request
//   cmd_ready  out  controller can accept a command
//   cmd_write  in   1 = write, 0 = read
//   cmd_addr   in   command address  [ADDR_W]
//   cmd_wdata  in   write data       [DATA_W]
//   rsp_valid  out  one-cycle strobe, rsp_rdata valid
//   rsp_rdata  out  captured read data, held until the next read [DATA_W]
//   busy       out  controller is not idle
//   init_done  out  RAM ready for commands
//   ram_ena    out  to ram2.ena
//   ram_wena   out  to ram2.wena
//   ram_addr   out  to ram2.addr     [ADDR_W]
//   ram_data   inout to ram2.data    [DATA_W]
// -----------------------------------------------------------------------------
module ram2_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              init_done,
    output logic              ram_ena,
    output logic              ram_wena,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_TA
    } state_t;

`ifdef RAM2_CTRL_INIT_EN
    localparam state_t            RESET_STATE = ST_INIT;
    localparam logic [ADDR_W-1:0] ADDR_LAST   = {ADDR_W{1'b1}};
`else
    localparam state_t            RESET_STATE = ST_IDLE;
`endif

    // Every output is a register loaded with the value belonging to the state
    // being entered, so the RAM pins and the bus enable never glitch.
    state_t              r_state;
    logic                r_cmd_ready;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_busy;
    logic                r_ram_ena;
    logic                r_ram_wena;
    logic                r_oe;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_wdata;

    state_t              w_state_next;
    logic                w_cmd_ready_next;
    logic                w_rsp_valid_next;
    logic                w_busy_next;
    logic                w_ena_next;
    logic                w_wena_next;
    logic                w_oe_next;
    logic [ADDR_W-1:0]   w_addr_next;
    logic [DATA_W-1:0]   w_wdata_next;

`ifdef RAM2_CTRL_INIT_EN
    logic                r_init_done;
    logic                w_init_done_next;
`endif

    always_comb begin
        w_state_next     = r_state;
        w_cmd_ready_next = 1'b0;
        w_rsp_valid_next = 1'b0;
        w_busy_next      = 1'b1;
        w_ena_next       = 1'b0;
        w_wena_next      = 1'b0;
        w_oe_next        = 1'b0;
        w_addr_next      = r_ram_addr;
        w_wdata_next     = r_wdata;
`ifdef RAM2_CTRL_INIT_EN
        w_init_done_next = r_init_done;
`endif
        case (r_state)
`ifdef RAM2_CTRL_INIT_EN
            // ram_addr doubles as the clear counter. ram_ena low means the
            // clear has not started yet (first cycle after reset).
            ST_INIT: begin
                w_wdata_next = '0;
                if (r_ram_ena && (r_ram_addr == ADDR_LAST)) begin
                    w_state_next     = ST_IDLE;
                    w_cmd_ready_next = 1'b1;
                    w_busy_next      = 1'b0;
                    w_init_done_next = 1'b1;
                end else begin
                    w_ena_next  = 1'b1;
                    w_wena_next = 1'b1;
                    w_oe_next   = 1'b1;
                    w_addr_next = r_ram_ena ? r_ram_addr + 1'b1 : '0;
                end
            end
`endif
            ST_IDLE: begin
                // Acceptance uses the registered ready the client actually saw.
                if (cmd_valid && r_cmd_ready) begin
                    w_addr_next = cmd_addr;
                    w_ena_next  = 1'b1;
                    if (cmd_write) begin
                        w_state_next = ST_WR;
                        w_wena_next  = 1'b1;
                        w_oe_next    = 1'b1;
                        w_wdata_next = cmd_wdata;
                    end else begin
                        w_state_next = ST_RD;
                    end
                end else begin
                    w_cmd_ready_next = 1'b1;
                    w_busy_next      = 1'b0;
                end
            end
            ST_RD: begin
                w_state_next     = ST_TA;
                w_rsp_valid_next = 1'b1;
            end
            ST_WR, ST_TA: begin
                w_state_next     = ST_IDLE;
                w_cmd_ready_next = 1'b1;
                w_busy_next      = 1'b0;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RESET_STATE;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_busy      <= 1'b0;
            r_ram_ena   <= 1'b0;
            r_ram_wena  <= 1'b0;
            r_oe        <= 1'b0;
            r_ram_addr  <= '0;
            r_wdata     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cmd_ready <= w_cmd_ready_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_busy      <= w_busy_next;
            r_ram_ena   <= w_ena_next;
            r_ram_wena  <= w_wena_next;
            r_oe        <= w_oe_next;
            r_ram_addr  <= w_addr_next;
            r_wdata     <= w_wdata_next;
            // RAM drives the bus throughout RD; capture at its closing edge.
            if (r_state == ST_RD) begin
                r_rsp_rdata <= ram_data;
            end
        end
    end

`ifdef RAM2_CTRL_INIT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_done <= 1'b0;
        end else begin
            r_init_done <= w_init_done_next;
        end
    end
    assign init_done = r_init_done;
`else
    assign init_done = 1'b1;
`endif

    // Drive only while writing; RAM owns the bus in RD, nobody in TA/IDLE.
    assign ram_data  = r_oe ? r_wdata : {DATA_W{1'bz}};

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign busy      = r_busy;
    assign ram_ena   = r_ram_ena;
    assign ram_wena  = r_ram_wena;
    assign ram_addr  = r_ram_addr;

endmodule
